sparse_pe_stream: RTL

Streaming, multi-lane successor to the sparse convolution PE. It holds one kernel's nonzero weights (value, col, row) in a local buffer and accepts feature nonzeros LANES at a time over a valid/ready stream. For each feature beat it forms the full cartesian product with every stored weight: one weight per cycle, LANES signed products per cycle, each tagged with its output-plane coordinate. Lanes whose output coordinate falls outside the valid output plane are masked. It sits between the sparse feature/weight fetch logic and the scatter accumulator.

---
 rtl/sparse_pe_pkg.sv | 29 ++
 rtl/sparse_pe_lane.sv | 39 +++
 rtl/sparse_pe_stream.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sparse_pe_pkg.sv
// rtl/sparse_pe_pkg.sv - shared constants, state encoding and coordinate check for the sparse PE
//   Default widths and geometry used as parameter defaults by sparse_pe_stream and sparse_pe_lane.
//   coord_ok(f, w, out_max): f >= w and f - w <= out_max.

package sparse_pe_pkg;

   localparam int COL_W_DEF   = 8;
   localparam int WORD_W_DEF  = 8;
   localparam int KERNEL_DEF  = 5;
   localparam int IMAGE_DEF   = 28;
   localparam int PROD_W_DEF  = 2 * WORD_W_DEF;
   localparam int OUT_MAX_DEF = IMAGE_DEF - KERNEL_DEF;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      READY = 2'd1,
      RUN   = 2'd2
   } state_t;

   // Coordinates are unsigned and narrower than 32 bits, so the 32-bit
   // difference never wraps once f >= w has been established.
   function automatic logic coord_ok(input logic [31:0] f, input logic [31:0] w,
                                     input int out_max);
      logic [31:0] d;
      d = f - w;
      return (f >= w) && (d <= 32'(out_max));
   endfunction

endpackage

// File: rtl/sparse_pe_lane.sv
// rtl/sparse_pe_lane.sv - one product lane: signed multiply plus output-coordinate translation and range mask
//   f_value/f_col/f_row/f_mask : one feature nonzero
//   w_value/w_col/w_row        : current weight
//   prod/col/row/mask          : masked product and output coordinate (zeroed when masked)

module sparse_pe_lane
   import sparse_pe_pkg::*;
#(
   parameter int COL_W   = COL_W_DEF,
   parameter int WORD_W  = WORD_W_DEF,
   parameter int OUT_MAX = OUT_MAX_DEF
) (
   input  logic signed [WORD_W-1:0]   f_value,
   input  logic        [COL_W-1:0]    f_col,
   input  logic        [COL_W-1:0]    f_row,
   input  logic                       f_mask,
   input  logic signed [WORD_W-1:0]   w_value,
   input  logic        [COL_W-1:0]    w_col,
   input  logic        [COL_W-1:0]    w_row,
   output logic signed [2*WORD_W-1:0] prod,
   output logic        [COL_W-1:0]    col,
   output logic        [COL_W-1:0]    row,
   output logic                       mask
);

   logic signed [2*WORD_W-1:0] full_prod;

   // Sign-extend both operands to the product width so the multiply is exact.
   assign full_prod = (2*WORD_W)'(f_value) * (2*WORD_W)'(w_value);

   assign mask = f_mask
              && coord_ok(32'(f_row), 32'(w_row), OUT_MAX)
              && coord_ok(32'(f_col), 32'(w_col), OUT_MAX);

   assign prod = mask ? full_prod : '0;
   assign row  = mask ? (f_row - w_row) : '0;
   assign col  = mask ? (f_col - w_col) : '0;

endmodule

// File: rtl/sparse_pe_stream.sv
// rtl/sparse_pe_stream.sv - multi-lane sparse convolution PE: weight buffer, beat register, product stream
//   w_*        : weight load stream (accepted only in LOAD)
//   f_*        : feature beat stream, LANES nonzeros per beat, plus in_channel tag
//   out_*      : product stream, one beat per stored weight per feature beat
//   data_out*  : LANES signed products and output coordinates

module sparse_pe_stream
   import sparse_pe_pkg::*;
#(
   parameter int COL_W   = COL_W_DEF,
   parameter int WORD_W  = WORD_W_DEF,
   parameter int CH_W    = 16,
   parameter int LANES   = 4,
   parameter int W_DEPTH = 32,
   parameter int KERNEL  = KERNEL_DEF,
   parameter int IMAGE   = IMAGE_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        w_valid,
   output logic                        w_ready,
   input  logic [WORD_W-1:0]           w_value,
   input  logic [COL_W-1:0]            w_col,
   input  logic [COL_W-1:0]            w_row,
   input  logic                        w_last,
   input  logic                        f_valid,
   output logic                        f_ready,
   input  logic [LANES*WORD_W-1:0]     f_value,
   input  logic [LANES*COL_W-1:0]      f_col,
   input  logic [LANES*COL_W-1:0]      f_row,
   input  logic [LANES-1:0]            f_mask,
   input  logic                        f_last,
   input  logic [CH_W-1:0]             in_channel,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*2*WORD_W-1:0]   data_out,
   output logic [LANES*COL_W-1:0]      data_out_cols,
   output logic [LANES*COL_W-1:0]      data_out_rows,
   output logic [LANES-1:0]            out_mask,
   output logic [CH_W-1:0]             out_channel,
   output logic                        out_last
);

   localparam int PROD_W  = 2 * WORD_W;
   localparam int OUT_MAX = IMAGE - KERNEL;
   localparam int CNT_W   = $clog2(W_DEPTH + 1);
   localparam int IDX_W   = $clog2(W_DEPTH);

   state_t             state;
   logic [CNT_W-1:0]   w_cnt;
   logic [IDX_W-1:0]   wi;

   logic [WORD_W-1:0]  w_val_mem [W_DEPTH];
   logic [COL_W-1:0]   w_col_mem [W_DEPTH];
   logic [COL_W-1:0]   w_row_mem [W_DEPTH];

   logic [LANES*WORD_W-1:0] b_value;
   logic [LANES*COL_W-1:0]  b_col;
   logic [LANES*COL_W-1:0]  b_row;
   logic [LANES-1:0]        b_mask;
   logic                    b_last;
   logic [CH_W-1:0]         b_channel;

   logic [LANES*PROD_W-1:0] l_prod;
   logic [LANES*COL_W-1:0]  l_col;
   logic [LANES*COL_W-1:0]  l_row;
   logic [LANES-1:0]        l_mask;

   logic advance, last_w, issue, w_hs, f_hs;

   assign advance = !out_valid || out_ready;
   assign last_w  = (CNT_W'(wi) == (w_cnt - CNT_W'(1)));
   assign issue   = (state == RUN) && advance;
   assign w_ready = (state == LOAD);
   // Re-arming f_ready on the final issue of a beat lets the next beat follow with no bubble.
   assign f_ready = (state == READY) || (issue && last_w && !b_last);
   assign w_hs    = w_valid && w_ready;
   assign f_hs    = f_valid && f_ready;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      sparse_pe_lane #(
         .COL_W   (COL_W),
         .WORD_W  (WORD_W),
         .OUT_MAX (OUT_MAX)
      ) u_lane (
         .f_value (b_value[i*WORD_W +: WORD_W]),
         .f_col   (b_col[i*COL_W +: COL_W]),
         .f_row   (b_row[i*COL_W +: COL_W]),
         .f_mask  (b_mask[i]),
         .w_value (w_val_mem[wi]),
         .w_col   (w_col_mem[wi]),
         .w_row   (w_row_mem[wi]),
         .prod    (l_prod[i*PROD_W +: PROD_W]),
         .col     (l_col[i*COL_W +: COL_W]),
         .row     (l_row[i*COL_W +: COL_W]),
         .mask    (l_mask[i])
      );
   end

   // Buffer contents need no reset: w_cnt bounds what is ever read.
   always_ff @(posedge clk) begin
      if (w_hs) begin
         w_val_mem[w_cnt[IDX_W-1:0]] <= w_value;
         w_col_mem[w_cnt[IDX_W-1:0]] <= w_col;
         w_row_mem[w_cnt[IDX_W-1:0]] <= w_row;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         b_value   <= '0;
         b_col     <= '0;
         b_row     <= '0;
         b_mask    <= '0;
         b_last    <= 1'b0;
         b_channel <= '0;
      end else if (f_hs) begin
         b_value   <= f_value;
         b_col     <= f_col;
         b_row     <= f_row;
         b_mask    <= f_mask;
         b_last    <= f_last;
         b_channel <= in_channel;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= LOAD;
         w_cnt         <= '0;
         wi            <= '0;
         out_valid     <= 1'b0;
         out_last      <= 1'b0;
         out_mask      <= '0;
         data_out      <= '0;
         data_out_cols <= '0;
         data_out_rows <= '0;
         out_channel   <= '0;
      end else begin
         if (issue) begin
            out_valid     <= 1'b1;
            out_last      <= b_last && last_w;
            out_mask      <= l_mask;
            data_out      <= l_prod;
            data_out_cols <= l_col;
            data_out_rows <= l_row;
            out_channel   <= b_channel;
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end

         case (state)
            LOAD: begin
               wi <= '0;
               if (w_hs) begin
                  w_cnt <= w_cnt + CNT_W'(1);
                  if (w_last || (w_cnt == CNT_W'(W_DEPTH - 1)))
                     state <= READY;
               end
            end
            READY: begin
               if (f_hs) begin
                  wi    <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (advance) begin
                  if (last_w) begin
                     wi <= '0;
                     if (b_last) begin
                        state <= LOAD;
                        w_cnt <= '0;
                     end else if (!f_hs) begin
                        state <= READY;
                     end
                  end else begin
                     wi <= wi + IDX_W'(1);
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule
